cpu_mem_arbiter: RTL

- Single-port memory arbiter directly downstream of cpu_datapath's memory interfaces.
- Accepts the fetch-stage instruction read port and the memory-stage data read/write port, and serialises them onto one physical memory port with a request/response handshake.
- Returns read data and a one-cycle response pulse to the requesting side only.
- Pipeline stall logic keys off the absence of a response.

---
 rtl/cpu_mem_arbiter_if.sv | 46 ++++
 rtl/cpu_mem_arbiter.sv | 111 +++++++++++
 2 files changed

// File: rtl/cpu_mem_arbiter_if.sv
// Bundle of the fetch, data and physical-memory ports of the CPU memory arbiter.
// The arbiter uses the slave view; the CPU/memory environment uses the master view.
interface cpu_mem_arbiter_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16
);
    logic                  imem_read;
    logic [ADDR_WIDTH-1:0] imem_address;
    logic [DATA_WIDTH-1:0] imem_rdata;
    logic                  imem_resp;

    logic                  dmem_read;
    logic                  dmem_write;
    logic [1:0]            dmem_byte_enable;
    logic [ADDR_WIDTH-1:0] dmem_address;
    logic [DATA_WIDTH-1:0] dmem_wdata;
    logic [DATA_WIDTH-1:0] dmem_rdata;
    logic                  dmem_resp;
    logic                  dmem_error;

    logic                  pmem_read;
    logic                  pmem_write;
    logic [1:0]            pmem_byte_enable;
    logic [ADDR_WIDTH-1:0] pmem_address;
    logic [DATA_WIDTH-1:0] pmem_wdata;
    logic [DATA_WIDTH-1:0] pmem_rdata;
    logic                  pmem_resp;

    modport slave (
        input  imem_read, imem_address,
        output imem_rdata, imem_resp,
        input  dmem_read, dmem_write, dmem_byte_enable, dmem_address, dmem_wdata,
        output dmem_rdata, dmem_resp, dmem_error,
        output pmem_read, pmem_write, pmem_byte_enable, pmem_address, pmem_wdata,
        input  pmem_rdata, pmem_resp
    );

    modport master (
        output imem_read, imem_address,
        input  imem_rdata, imem_resp,
        output dmem_read, dmem_write, dmem_byte_enable, dmem_address, dmem_wdata,
        input  dmem_rdata, dmem_resp, dmem_error,
        input  pmem_read, pmem_write, pmem_byte_enable, pmem_address, pmem_wdata,
        output pmem_rdata, pmem_resp
    );
endinterface

// File: rtl/cpu_mem_arbiter.sv
// Serialises instruction fetch and data accesses onto one physical memory port.
// Define CPU_MEM_ARB_ROUND_ROBIN_EN to alternate grants when both sides request.
//
// state  | meaning
// IDLE   | no transaction; arbitrate this cycle
// I_BUSY | instruction read outstanding on pmem
// D_BUSY | data read or write outstanding on pmem
module cpu_mem_arbiter #(
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input logic             clk,
    input logic             reset,
    cpu_mem_arbiter_if.slave bus
);
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY} state_t;

    state_t                state, state_nxt;
    logic                  grant_d, grant_i;
    logic                  d_req, expired;
    logic                  last_grant_d;
    logic                  op_write;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [1:0]            be_q;
    logic [TW-1:0]         tmr;

    assign d_req   = bus.dmem_read | bus.dmem_write;
    assign expired = (TIMEOUT_CYCLES != 0) && (state != IDLE) && !bus.pmem_resp
                     && (32'(tmr) == TIMEOUT_CYCLES - 1);

    always_comb begin
        grant_d = 1'b0;
        grant_i = 1'b0;
`ifdef CPU_MEM_ARB_ROUND_ROBIN_EN
        if (d_req && bus.imem_read) begin
            grant_d = !last_grant_d;
            grant_i = last_grant_d;
        end else begin
            grant_d = d_req;
            grant_i = bus.imem_read;
        end
`else
        grant_d = d_req;
        grant_i = bus.imem_read && !d_req;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (grant_d)      state_nxt = D_BUSY;
                else if (grant_i) state_nxt = I_BUSY;
            end
            I_BUSY, D_BUSY: begin
                if (bus.pmem_resp || expired) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Responses are combinational with pmem_resp so the pipeline can advance in that same cycle.
    always_comb begin
        bus.pmem_read  = (state == I_BUSY) || ((state == D_BUSY) && !op_write);
        bus.pmem_write = (state == D_BUSY) && op_write;
        bus.imem_resp  = !reset && (state == I_BUSY) && bus.pmem_resp;
        bus.dmem_resp  = !reset && (state == D_BUSY) && bus.pmem_resp;
        bus.dmem_error = !reset && (state == D_BUSY) && expired;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q       <= '0;
            wdata_q      <= '0;
            be_q         <= '0;
            op_write     <= 1'b0;
            tmr          <= '0;
            last_grant_d <= 1'b0;
        end else if (state == IDLE) begin
            tmr <= '0;
            if (grant_d) begin
                addr_q   <= bus.dmem_address;
                wdata_q  <= bus.dmem_wdata;
                op_write <= bus.dmem_write;
                be_q     <= bus.dmem_write ? bus.dmem_byte_enable : 2'b11;
            end else if (grant_i) begin
                addr_q   <= bus.imem_address;
                op_write <= 1'b0;
                be_q     <= 2'b11;
            end
        end else begin
            last_grant_d <= bus.pmem_resp ? (state == D_BUSY) : last_grant_d;
            if (!bus.pmem_resp && !expired) tmr <= tmr + 1'b1;
        end
    end

    assign bus.pmem_address     = addr_q;
    assign bus.pmem_wdata       = wdata_q;
    assign bus.pmem_byte_enable = be_q;
    assign bus.imem_rdata       = bus.pmem_rdata;
    assign bus.dmem_rdata       = bus.pmem_rdata;
endmodule
